// File: rtl/norm_pkg.sv
// rtl/norm_pkg.sv - shared state encodings and stage widths for normalizer_32
// Stage k of the normalizer shifts by 2^k; stage_width maps index to that amount.
package norm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S4   = 3'd1,
    ST_S3   = 3'd2,
    ST_S2   = 3'd3,
    ST_S1   = 3'd4,
    ST_S0   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [4:0] SW_16 = 5'd16;
  localparam logic [4:0] SW_8  = 5'd8;
  localparam logic [4:0] SW_4  = 5'd4;
  localparam logic [4:0] SW_2  = 5'd2;
  localparam logic [4:0] SW_1  = 5'd1;

  function automatic logic [4:0] stage_width(input logic [2:0] k);
    case (k)
      3'd4:    return SW_16;
      3'd3:    return SW_8;
      3'd2:    return SW_4;
      3'd1:    return SW_2;
      default: return SW_1;
    endcase
  endfunction

endpackage

// File: rtl/norm_stage.sv
// rtl/norm_stage.sv - one combinational normalize step, shared across stages S4..S0
// Sign-compare path exists only when NORMALIZER_32_ARITH_EN is defined.
module norm_stage
  import norm_pkg::*;
(
  input  logic [31:0] w,
  input  logic [2:0]  idx,
  input  logic        arith,
  output logic        hit,
  output logic [31:0] w_shift
);

  logic [4:0]  n;
  logic [31:0] top_mask;

  always_comb begin
    n        = stage_width(idx);
    top_mask = ~(32'hFFFF_FFFF >> n);
    w_shift  = w << n;
`ifdef NORMALIZER_32_ARITH_EN
    // Arith mode looks at n+1 top bits: all must match the sign bit.
    if (arith)
      hit = (((w ^ {32{w[31]}}) & {1'b1, top_mask[31:1]}) == 32'd0);
    else
      hit = ((w & top_mask) == 32'd0);
`else
    hit = ((w & top_mask) == 32'd0);
`endif
  end

`ifndef NORMALIZER_32_ARITH_EN
  logic unused_arith;
  assign unused_arith = arith;
`endif

endmodule

// File: rtl/normalizer_32.sv
// rtl/normalizer_32.sv - multi-cycle 32-bit leading-zero / redundant-sign normalizer
// Arith (redundant-sign) mode is enabled by defining NORMALIZER_32_ARITH_EN.
module normalizer_32
  import norm_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] X,
  input  logic        Arith,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Sh,
  output logic [4:0]  Sa,
  output logic        Zero
);

  state_t      state_q, state_d;
  logic [31:0] w_q;
  logic [4:0]  sa_q;
  logic        zero_q;
  logic [2:0]  stage_idx;
  logic        stage_en;
  logic        hit;
  logic [31:0] w_shift;
  logic [31:0] w_next;
  logic [4:0]  sa_next;
  logic        final_zero;
  logic        stage_arith;

`ifdef NORMALIZER_32_ARITH_EN
  logic arith_q;
  assign stage_arith = arith_q;
`else
  logic unused_arith_in;
  assign unused_arith_in = Arith;
  assign stage_arith     = 1'b0;
`endif

  norm_stage u_stage (
    .w       (w_q),
    .idx     (stage_idx),
    .arith   (stage_arith),
    .hit     (hit),
    .w_shift (w_shift)
  );

  always_comb begin
    state_d   = state_q;
    stage_idx = 3'd0;
    stage_en  = 1'b0;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_S4;
      ST_S4:   begin state_d = ST_S3;   stage_idx = 3'd4; stage_en = 1'b1; end
      ST_S3:   begin state_d = ST_S2;   stage_idx = 3'd3; stage_en = 1'b1; end
      ST_S2:   begin state_d = ST_S1;   stage_idx = 3'd2; stage_en = 1'b1; end
      ST_S1:   begin state_d = ST_S0;   stage_idx = 3'd1; stage_en = 1'b1; end
      ST_S0:   begin state_d = ST_DONE; stage_idx = 3'd0; stage_en = 1'b1; end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero is decided from the post-S0 values so it lands together with DONE.
  always_comb begin
    w_next  = hit ? w_shift : w_q;
    sa_next = hit ? (sa_q | (5'd1 << stage_idx)) : sa_q;
`ifdef NORMALIZER_32_ARITH_EN
    final_zero = (w_next == 32'd0) ||
                 (arith_q && (sa_next == 5'd31) && (w_next == 32'h8000_0000));
`else
    final_zero = (w_next == 32'd0);
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      w_q     <= 32'd0;
      sa_q    <= 5'd0;
      zero_q  <= 1'b0;
`ifdef NORMALIZER_32_ARITH_EN
      arith_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && Start) begin
        w_q     <= X;
        sa_q    <= 5'd0;
        zero_q  <= 1'b0;
`ifdef NORMALIZER_32_ARITH_EN
        arith_q <= Arith;
`endif
      end else if (stage_en) begin
        w_q  <= w_next;
        sa_q <= sa_next;
        if (state_q == ST_S0) zero_q <= final_zero;
      end
    end
  end

  assign Busy = (state_q != ST_IDLE);
  assign Done = (state_q == ST_DONE);
  assign Sh   = w_q;
  assign Sa   = sa_q;
  assign Zero = zero_q;

endmodule

// File: tb/tb_normalizer_32.sv
// tb/tb_normalizer_32.sv - directed self-checking bench for normalizer_32
// Expected values for Arith vectors follow NORMALIZER_32_ARITH_EN.
module tb_normalizer_32;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [31:0] X;
  logic        Arith;
  logic        Busy;
  logic        Done;
  logic [31:0] Sh;
  logic [4:0]  Sa;
  logic        Zero;

  int checks   = 0;
  int failures = 0;
  int done_cnt;

  normalizer_32 dut (
    .Clk   (Clk),
    .Rst   (Rst),
    .Start (Start),
    .X     (X),
    .Arith (Arith),
    .Busy  (Busy),
    .Done  (Done),
    .Sh    (Sh),
    .Sa    (Sa),
    .Zero  (Zero)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Called 1 ns after an edge; Start is sampled at the next edge (edge 0).
  // Returns in cycle 7 after checking the held result.
  task automatic run_op(input string tag, input logic [31:0] x, input logic a,
                        input logic [31:0] exp_sh, input logic [4:0] exp_sa,
                        input logic exp_zero);
    Start = 1'b1;
    X     = x;
    Arith = a;
    step();
    Start = 1'b0;
    X     = ~x;
    Arith = ~a;
    for (int c = 1; c <= 6; c++) begin
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_done"}, 32'(Done), (c == 6) ? 32'd1 : 32'd0);
      if (c < 6) step();
    end
    chk({tag, "_sh"},   Sh,         exp_sh);
    chk({tag, "_sa"},   32'(Sa),    32'(exp_sa));
    chk({tag, "_zero"}, 32'(Zero),  32'(exp_zero));
    step();
    chk({tag, "_idle_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(Done), 32'd0);
    chk({tag, "_held_sh"},   Sh,        exp_sh);
    chk({tag, "_held_sa"},   32'(Sa),   32'(exp_sa));
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; X = 32'd0; Arith = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_sh",   Sh,        32'd0);
    chk("rst_sa",   32'(Sa),   32'd0);
    chk("rst_zero", 32'(Zero), 32'd0);
    Rst = 1'b0;
    step();

    // Back-to-back chain: each run_op starts in the cycle right after the previous Done.
    run_op("lz_one",  32'h0000_0001, 1'b0, 32'h8000_0000, 5'd31, 1'b0);
    run_op("lz_f0",   32'h00F0_0000, 1'b0, 32'hF000_0000, 5'd8,  1'b0);
    run_op("lz_msb",  32'h8000_0000, 1'b0, 32'h8000_0000, 5'd0,  1'b0);
    run_op("lz_three",32'h0000_0003, 1'b0, 32'hC000_0000, 5'd30, 1'b0);
    run_op("lz_zero", 32'h0000_0000, 1'b0, 32'h0000_0000, 5'd31, 1'b1);
    run_op("ar_zero", 32'h0000_0000, 1'b1, 32'h0000_0000, 5'd31, 1'b1);
`ifdef NORMALIZER_32_ARITH_EN
    run_op("ar_ffff0000", 32'hFFFF_0000, 1'b1, 32'h8000_0000, 5'd15, 1'b0);
    run_op("ar_ones",     32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 5'd31, 1'b1);
    run_op("ar_one",      32'h0000_0001, 1'b1, 32'h4000_0000, 5'd30, 1'b0);
`else
    run_op("ar_ffff0000", 32'hFFFF_0000, 1'b1, 32'hFFFF_0000, 5'd0,  1'b0);
    run_op("ar_ones",     32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 5'd0,  1'b0);
    run_op("ar_one",      32'h0000_0001, 1'b1, 32'h8000_0000, 5'd31, 1'b0);
`endif

    // Reset while in S3 discards the operation.
    Start = 1'b1; X = 32'h0000_0001; Arith = 1'b0;
    step();
    Start = 1'b0;
    step();
    chk("mid_sa_before_rst", 32'(Sa), 32'd16);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_sa",   32'(Sa),   32'd0);
    chk("mid_rst_sh",   Sh,        32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      if (Done) done_cnt++;
      step();
    end
    chk("mid_rst_no_done", 32'(done_cnt), 32'd0);

    // Reset wins over a simultaneous Start.
    Rst = 1'b1; Start = 1'b1; X = 32'h0000_0001;
    step();
    Rst = 1'b0; Start = 1'b0;
    chk("rst_prio_busy", 32'(Busy), 32'd0);
    step();
    chk("rst_prio_idle", 32'(Busy), 32'd0);

    // Start pulses during S2 and DONE are ignored.
    Start = 1'b1; X = 32'h00F0_0000; Arith = 1'b0;
    step();
    Start = 1'b0;
    done_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      if (Done) done_cnt++;
      if (c == 7) chk("ign_idle_c7", 32'(Busy), 32'd0);
      Start = (c == 3) || (c == 6);
      X = 32'h0000_0001;
      step();
    end
    Start = 1'b0;
    chk("ign_one_done", 32'(done_cnt), 32'd1);
    chk("ign_sh",       Sh,            32'hF000_0000);
    chk("ign_sa",       32'(Sa),       32'd8);
    chk("ign_busy",     32'(Busy),     32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
